// File: rtl/td4_fpga_computer.sv
// TD4-style 4-bit CPU top level: instruction ROM, A/B/OUT/PC registers,
// carry flag, step-rate divider, switch synchronizer and 7-segment outputs.
module td4_fpga_computer #(
   parameter int unsigned  CLK_DIV   = 100_000_000,
   // Entry i of the 16x8 program lives in bits [8*i+7 : 8*i].
   parameter logic [127:0] ROM_IMAGE = 128'h0000_0000_0000_0000_0000_00F0_E151_9070
) (
   input  logic       CLK,
   input  logic [0:0] KEY,
   input  logic [3:0] SW,
   output logic [0:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1
);

   localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_A  = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_B  = 4'b0111;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_IM = 4'b1011;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [3:0]       sw_meta_q, sw_meta_d;
   logic [3:0]       sw_sync_q, sw_sync_d;
   logic [3:0]       a_q, a_d;
   logic [3:0]       b_q, b_d;
   logic [3:0]       out_q, out_d;
   logic [3:0]       pc_q, pc_d;
   logic             carry_q, carry_d;

   logic             step_en;
   logic [7:0]       instr;
   logic [3:0]       opcode;
   logic [3:0]       imm;
   logic [3:0]       src;
   logic [4:0]       sum;

   assign step_en = (div_cnt_q == DIV_LAST);
   assign instr   = ROM_IMAGE[{pc_q, 3'b000} +: 8];
   assign opcode  = instr[7:4];
   assign imm     = instr[3:0];
   assign sum     = {1'b0, src} + {1'b0, imm};

   // Active-low hex digit decode, bit0 = segment a ... bit6 = segment g.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Adder source select: each opcode picks A, B, the switches or zero.
   always_comb begin
      src = 4'h0;
      case (opcode)
         OP_ADD_A, OP_MOV_BA:           src = a_q;
         OP_ADD_B, OP_MOV_AB, OP_OUT_B: src = b_q;
         OP_IN_A, OP_IN_B:              src = sw_sync_q;
         default:                       src = 4'h0;
      endcase
   end

   // Next-state: divider, synchronizer, and one instruction per step enable.
   always_comb begin
      div_cnt_d = step_en ? '0 : div_cnt_q + 1'b1;
      sw_meta_d = SW;
      sw_sync_d = sw_meta_q;
      a_d       = a_q;
      b_d       = b_q;
      out_d     = out_q;
      pc_d      = pc_q;
      carry_d   = carry_q;
      if (step_en) begin
         pc_d    = pc_q + 4'd1;
         carry_d = sum[4];
         case (opcode)
            OP_ADD_A, OP_MOV_A, OP_MOV_AB, OP_IN_A: a_d   = sum[3:0];
            OP_ADD_B, OP_MOV_B, OP_MOV_BA, OP_IN_B: b_d   = sum[3:0];
            OP_OUT_B, OP_OUT_IM:                    out_d = sum[3:0];
            OP_JMP: pc_d = imm;
            OP_JNC: begin
               carry_d = 1'b0;
               if (!carry_q) pc_d = imm;
            end
            default: carry_d = 1'b0;
         endcase
      end
   end

   // State registers; reset wins over a step falling on the same edge.
   always_ff @(posedge CLK) begin
      if (KEY[0]) begin
         div_cnt_q <= '0;
         sw_meta_q <= 4'h0;
         sw_sync_q <= 4'h0;
         a_q       <= 4'h0;
         b_q       <= 4'h0;
         out_q     <= 4'h0;
         pc_q      <= 4'h0;
         carry_q   <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
         a_q       <= a_d;
         b_q       <= b_d;
         out_q     <= out_d;
         pc_q      <= pc_d;
         carry_q   <= carry_d;
      end
   end

   // Board outputs are pure decodes of registered state.
   always_comb begin
      HEX0 = seg7(out_q);
      HEX1 = seg7(pc_q);
      LEDR = carry_q;
   end

endmodule

// File: tb/tb_td4_fpga_computer.sv
// Self-checking bench: two CPUs (default ROM and a feature-exercising ROM)
// compared cycle by cycle against an instruction-level reference model.
module tb_td4_fpga_computer;

   localparam int DIV = 4;
   // Custom program, entry 0 first:
   // IN A | MOV B,A | OUT B | MOV A,15 | ADD A,1 | JNC 7 | JNC 8 | OUT 5
   // NOP80 | IN B,3 | MOV A,B+2 | OUT B+1 | OUT 7 | ADD B,5 | NOPD0 | ADD A,10
   localparam logic [127:0] CUSTOM_ROM = 128'h0AD0_55B7_9112_6380_B5E8_E701_3F90_4020;

   logic       clk;
   logic [0:0] key;
   logic [3:0] sw;
   logic [0:0] ledr [2];
   logic [6:0] hex0 [2];
   logic [6:0] hex1 [2];

   int checks = 0;
   int errors = 0;

   logic [7:0] rom    [2][16];
   logic [6:0] segTab [16];
   int mA [2], mB [2], mOut [2], mPc [2], mC [2];
   int mCnt, mSync1, mSync2;

   td4_fpga_computer #(.CLK_DIV(DIV)) dutDef (
      .CLK(clk), .KEY(key), .SW(sw), .LEDR(ledr[0]), .HEX0(hex0[0]), .HEX1(hex1[0]));

   td4_fpga_computer #(.CLK_DIV(DIV), .ROM_IMAGE(CUSTOM_ROM)) dutCus (
      .CLK(clk), .KEY(key), .SW(sw), .LEDR(ledr[1]), .HEX0(hex0[1]), .HEX1(hex1[1]));

   // Free-running 100 MHz-style clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Executes one instruction of CPU d at the ISA level.
   task automatic execStep(input int d);
      int op, im, s, nextPc;
      op = int'(rom[d][mPc[d]][7:4]);
      im = int'(rom[d][mPc[d]][3:0]);
      nextPc = (mPc[d] + 1) % 16;
      case (op)
         0:  begin s = mA[d] + im;  mA[d] = s % 16;   mC[d] = s / 16; end
         1:  begin s = mB[d] + im;  mA[d] = s % 16;   mC[d] = s / 16; end
         2:  begin s = mSync2 + im; mA[d] = s % 16;   mC[d] = s / 16; end
         3:  begin mA[d] = im; mC[d] = 0; end
         4:  begin s = mA[d] + im;  mB[d] = s % 16;   mC[d] = s / 16; end
         5:  begin s = mB[d] + im;  mB[d] = s % 16;   mC[d] = s / 16; end
         6:  begin s = mSync2 + im; mB[d] = s % 16;   mC[d] = s / 16; end
         7:  begin mB[d] = im; mC[d] = 0; end
         9:  begin s = mB[d] + im;  mOut[d] = s % 16; mC[d] = s / 16; end
         11: begin mOut[d] = im; mC[d] = 0; end
         14: begin if (mC[d] == 0) nextPc = im; mC[d] = 0; end
         15: begin nextPc = im; mC[d] = 0; end
         default: mC[d] = 0;
      endcase
      mPc[d] = nextPc;
   endtask

   // One clock edge: advance the models with the inputs seen at that edge.
   task automatic tick();
      @(posedge clk);
      if (key[0]) begin
         mCnt = 0; mSync1 = 0; mSync2 = 0;
         for (int d = 0; d < 2; d++) begin
            mA[d] = 0; mB[d] = 0; mOut[d] = 0; mPc[d] = 0; mC[d] = 0;
         end
      end else begin
         if (mCnt == DIV - 1) begin
            mCnt = 0;
            for (int d = 0; d < 2; d++) execStep(d);
         end else begin
            mCnt++;
         end
         mSync2 = mSync1;
         mSync1 = int'(sw);
      end
      #1;
   endtask

   // Two reset cycles, then release.
   task automatic applyReset();
      key = 1'b1;
      tick();
      tick();
      key = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      key = 1'b1;
      sw  = 4'h0;
      repeat (3) tick();
      key = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (hex0[d] !== 7'h40) begin
            errors++; $display("[TB] FAIL reset_hex0 dut%0d got %h expected 40", d, hex0[d]);
         end
         checks++;
         if (hex1[d] !== 7'h40) begin
            errors++; $display("[TB] FAIL reset_hex1 dut%0d got %h expected 40", d, hex1[d]);
         end
         checks++;
         if (ledr[d] !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ledr dut%0d got %b expected 0", d, ledr[d]);
         end
      end
      n = 0;
      while (hex1[0] === 7'h40 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n != DIV || hex1[0] !== 7'h79) begin
         errors++;
         $display("[TB] FAIL first_step_latency got %0d cycles hex1=%h expected %0d cycles hex1=79",
                  n, hex1[0], DIV);
      end
   endtask

   task automatic test_default_program();
      int ledCycles;
      ledCycles = 0;
      applyReset();
      for (int i = 1; i <= 60 * DIV; i++) begin
         sw = 4'($urandom);
         tick();
         if (ledr[0] === 1'b1) ledCycles++;
         checks++;
         if (hex0[0] !== segTab[mOut[0]] || hex1[0] !== segTab[mPc[0]] || ledr[0] !== 1'(mC[0])) begin
            errors++;
            $display("[TB] FAIL default_model t=%0d got %h/%h/%b expected %h/%h/%0d", i,
                     hex0[0], hex1[0], ledr[0], segTab[mOut[0]], segTab[mPc[0]], mC[0]);
         end
         if (i == 2 * DIV) begin
            checks++;
            if (hex0[0] !== 7'h40) begin
               errors++; $display("[TB] FAIL default_step2_hex0 got %h expected 40", hex0[0]);
            end
         end
         if (i == 5 * DIV) begin
            checks++;
            if (hex0[0] !== 7'h79) begin
               errors++; $display("[TB] FAIL default_step5_hex0 got %h expected 79", hex0[0]);
            end
         end
      end
      checks++;
      if (ledCycles != DIV) begin
         errors++;
         $display("[TB] FAIL default_carry_width got %0d cycles expected %0d", ledCycles, DIV);
      end
   endtask

   task automatic test_custom_program();
      sw = 4'hA;
      applyReset();
      for (int i = 1; i <= 8 * DIV; i++) begin
         tick();
         if (i == 3 * DIV) begin
            checks++;
            if (hex0[1] !== 7'h08) begin
               errors++; $display("[TB] FAIL in_path_hex0 got %h expected 08", hex0[1]);
            end
         end
         if (i == 5 * DIV) begin
            checks++;
            if (ledr[1] !== 1'b1) begin
               errors++; $display("[TB] FAIL add_carry_ledr got %b expected 1", ledr[1]);
            end
         end
         if (i == 6 * DIV) begin
            checks++;
            if (hex1[1] !== 7'h02 || ledr[1] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL jnc_not_taken got hex1=%h ledr=%b expected 02/0", hex1[1], ledr[1]);
            end
         end
         if (i == 7 * DIV) begin
            checks++;
            if (hex1[1] !== 7'h00) begin
               errors++; $display("[TB] FAIL jnc_taken got hex1=%h expected 00", hex1[1]);
            end
         end
         if (i == 8 * DIV) begin
            checks++;
            if (hex1[1] !== 7'h10 || hex0[1] !== 7'h08 || ledr[1] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL unknown_opcode got %h/%h/%b expected 08/10/0",
                        hex0[1], hex1[1], ledr[1]);
            end
         end
      end
      for (int i = 0; i < 200; i++) begin
         sw = 4'($urandom);
         tick();
         checks++;
         if (hex0[1] !== segTab[mOut[1]] || hex1[1] !== segTab[mPc[1]] || ledr[1] !== 1'(mC[1])) begin
            errors++;
            $display("[TB] FAIL custom_model t=%0d got %h/%h/%b expected %h/%h/%0d", i,
                     hex0[1], hex1[1], ledr[1], segTab[mOut[1]], segTab[mPc[1]], mC[1]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int n;
      n = 0;
      while (mCnt != DIV - 1 && n < 2 * DIV) begin
         tick();
         n++;
      end
      checks++;
      if (mCnt != DIV - 1) begin
         errors++; $display("[TB] FAIL mid_reset_align got cnt %0d expected %0d", mCnt, DIV - 1);
      end
      key = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (hex0[d] !== 7'h40 || hex1[d] !== 7'h40 || ledr[d] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset dut%0d got %h/%h/%b expected 40/40/0",
                     d, hex0[d], hex1[d], ledr[d]);
         end
      end
      key = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         sw  = 4'($urandom);
         key = ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0;
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (hex0[d] !== segTab[mOut[d]] || hex1[d] !== segTab[mPc[d]] || ledr[d] !== 1'(mC[d])) begin
               errors++;
               $display("[TB] FAIL random_model dut%0d t=%0d got %h/%h/%b expected %h/%h/%0d", d, i,
                        hex0[d], hex1[d], ledr[d], segTab[mOut[d]], segTab[mPc[d]], mC[d]);
            end
         end
      end
      key = 1'b0;
   endtask

   // Test sequence.
   initial begin
      segTab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      rom[0] = '{8'h70, 8'h90, 8'h51, 8'hE1, 8'hF0, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      rom[1] = '{8'h20, 8'h40, 8'h90, 8'h3F, 8'h01, 8'hE7, 8'hE8, 8'hB5,
                 8'h80, 8'h63, 8'h12, 8'h91, 8'hB7, 8'h55, 8'hD0, 8'h0A};
      mCnt = 0; mSync1 = 0; mSync2 = 0;
      for (int d = 0; d < 2; d++) begin
         mA[d] = 0; mB[d] = 0; mOut[d] = 0; mPc[d] = 0; mC[d] = 0;
      end
      key = 1'b1;
      sw  = 4'h0;
      test_reset();
      test_default_program();
      test_custom_program();
      test_mid_reset();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
